rtc_set_ctrl: RTL
=================

Name: rtc_set_ctrl

Overview:
- Time-setting controller for the six-digit BCD real-time clock (HH:MM:SS).
- Freezes the counter chain, lets the user edit hours, minutes and seconds with two buttons, then commits the new value to the counters with a one-cycle load strobe.
- Sits between the button inputs and the RTC counter chain, in the same clock domain as the chain's 1 Hz tick.

Parameters:
- TIMEOUT_TICKS, 30, number of tick strobes with no button edge before an edit is abandoned; legal range 1..63.
- TO_W, 6, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_TICKS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle strobe, 1 Hz, from the clock divider
- btn_mode  in  1  mode button, already synchronised and debounced, level
- btn_inc  in  1  increment button, already synchronised and debounced, level
- cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl  in  4 each  live BCD time from the counter chain
- run_en  out  1  counter chain enable; 1 = time advances
- load  out  1  one-cycle strobe; the counters load the ld_* values
- ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl  out  4 each  shadow BCD time being edited or committed
- edit_field  out  2  field being edited: 0 = none, 1 = hours, 2 = minutes, 3 = seconds
- blink  out  1  display blink phase for the edited field

Behaviour:
- Reset values (rst=1 at a clock edge):
  - state=RUN, run_en=1, load=0, all ld_*=0, edit_field=0, blink=0, timeout count=0.
  - The button history registers load the current btn_* levels, so a button held through reset produces no edge.
- Edge detection:
  - mode_e = btn_mode & ~btn_mode_q; inc_e = btn_inc & ~btn_inc_q.
  - The history registers update every cycle.
  - An edge is acted on in the cycle it is detected.
- States: RUN, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT.
- RUN:
  - run_en=1, edit_field=0, blink=0, inc_e is ignored.
  - On mode_e: copy all cur_* into ld_*, clear the timeout count, go to EDIT_HR.
  - run_en falls to 0 on the same edge that enters EDIT_HR, so the captured value is the frozen value.
- EDIT states:
  - run_en=0, and edit_field = 1, 2 or 3 for EDIT_HR, EDIT_MIN, EDIT_SEC.
  - mode_e advances HR→MIN→SEC→COMMIT.
  - inc_e increments the current field in BCD:
    - Hours wrap 23→00; the low digit carries 9→0 and increments the high digit.
    - Minutes and seconds wrap 59→00.
    - Other fields are unchanged.
  - mode_e and inc_e in the same cycle: mode wins and the increment is discarded.
  - Any edge (mode or inc) clears the timeout count. Otherwise each tick increments it.
  - When the count would reach TIMEOUT_TICKS: go to RUN with no load. ld_* keep their values, and the counters resume from their frozen value.
  - blink toggles on every tick while in an EDIT state, and is forced to 0 on entry to EDIT_HR.
- COMMIT:
  - Lasts exactly one cycle: load=1, run_en=0, ld_* stable, edit_field=0.
  - The next state is RUN with load=0.
  - Edges and ticks are ignored in COMMIT.
- Timing:
  - Latency from the mode_e that leaves EDIT_SEC to load=1 is one clock.
  - run_en returns to 1 on the cycle after load.
- Invalid captured time (e.g. hours of 25 or above): wrap the value as if it were at its maximum, i.e. the next inc yields 00. No other checking.
- rst during any state: abort immediately to the reset values, with no load pulse.
- load is never asserted outside COMMIT, and is never asserted for two consecutive cycles.

Test Plan:
- Capture: with cur=12:34:56, pulse btn_mode → next cycle edit_field=1, run_en=0, ld_*=1,2,3,4,5,6.
- Hour wrap: in EDIT_HR with ld=23:xx:xx, one inc edge → ld_hrm=0, ld_hrl=0. From 09, one inc → 10.
- Full edit: capture 12:34:56, then inc×2 in hours, mode, inc in minutes, mode, inc×4 in seconds, mode → exactly one load pulse with ld=14:35:00 (seconds 56+4 wraps to 00). run_en=1 on the following cycle.
- Timeout: with TIMEOUT_TICKS=3, enter edit and apply 3 ticks with no buttons → back in RUN after the third tick, load never pulses, run_en=1. An inc edge between ticks restarts the count.
- Simultaneous edges and held button: mode and inc rising in the same cycle in EDIT_MIN → moves to EDIT_SEC with minutes unchanged. btn_mode held high through reset release → stays in RUN.
- Reset mid-edit: assert rst in EDIT_MIN → next cycle in RUN with run_en=1, load=0, ld_*=0, blink=0.

Source files
------------

// File: rtl/rtc_set_ctrl.sv
// Time-setting controller for a six-digit BCD RTC: freezes the counter chain,
// edits HH:MM:SS with mode/inc buttons, then commits with a one-cycle load strobe.
module rtc_set_ctrl #(
   parameter int TIMEOUT_TICKS = 30,
   parameter int TO_W          = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_hrm,
   input  logic [3:0] cur_hrl,
   input  logic [3:0] cur_minm,
   input  logic [3:0] cur_minl,
   input  logic [3:0] cur_secm,
   input  logic [3:0] cur_secl,
   output logic       run_en,
   output logic       load,
   output logic [3:0] ld_hrm,
   output logic [3:0] ld_hrl,
   output logic [3:0] ld_minm,
   output logic [3:0] ld_minl,
   output logic [3:0] ld_secm,
   output logic [3:0] ld_secl,
   output logic [1:0] edit_field,
   output logic       blink
);

   // Encoding chosen so state[1:0] is directly the edit_field value
   // (RUN and COMMIT both map to 0).
   typedef enum logic [2:0] {
      RUN      = 3'd0,
      EDIT_HR  = 3'd1,
      EDIT_MIN = 3'd2,
      EDIT_SEC = 3'd3,
      COMMIT   = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic            btn_mode_q, btn_inc_q;
   logic            mode_e, inc_e;
   logic [TO_W-1:0] to_cnt, to_cnt_nx;
   logic [23:0]     ld, ld_nx;
   logic            blink_nx;

   assign mode_e = btn_mode & ~btn_mode_q;
   assign inc_e  = btn_inc & ~btn_inc_q;

   assign {ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl} = ld;

   // Anything at or above the field maximum (including invalid captures) wraps to 00.
   function automatic logic [7:0] bcd_inc(input logic [3:0] hi, input logic [3:0] lo,
                                          input logic [3:0] hi_max, input logic [3:0] lo_max);
      if (hi > hi_max || (hi == hi_max && lo >= lo_max)) return 8'h00;
      else if (lo >= 4'd9)                                 return {hi + 4'd1, 4'd0};
      else                                                 return {hi, lo + 4'd1};
   endfunction

   always_comb begin
      // NOTE: every output and next-state signal gets a default first so no path infers a latch.
      state_nx   = state;
      ld_nx      = ld;
      to_cnt_nx  = to_cnt;
      blink_nx   = blink;
      run_en     = 1'b1;
      load       = 1'b0;
      edit_field = state[1:0];

      unique case (state)
         RUN: begin
            if (mode_e) begin
               ld_nx     = {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl};
               to_cnt_nx = '0;
               blink_nx  = 1'b0;
               state_nx  = EDIT_HR;
            end
         end
         EDIT_HR, EDIT_MIN, EDIT_SEC: begin
            run_en = 1'b0;
            if (tick) blink_nx = ~blink;
            if (mode_e) begin
               to_cnt_nx = '0;
               state_nx  = state_t'(state + 3'd1);
            end else if (inc_e) begin
               to_cnt_nx = '0;
               unique case (state)
                  EDIT_HR:  ld_nx[23:16] = bcd_inc(ld[23:20], ld[19:16], 4'd2, 4'd3);
                  EDIT_MIN: ld_nx[15:8]  = bcd_inc(ld[15:12], ld[11:8],  4'd5, 4'd9);
                  default:  ld_nx[7:0]   = bcd_inc(ld[7:4],   ld[3:0],   4'd5, 4'd9);
               endcase
            end else if (tick) begin
               if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                  to_cnt_nx = '0;
                  state_nx  = RUN;
               end else begin
                  to_cnt_nx = to_cnt + 1'b1;
               end
            end
            if (state_nx == RUN || state_nx == COMMIT) blink_nx = 1'b0;
         end
         COMMIT: begin
            run_en   = 1'b0;
            load     = 1'b1;
            state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      if (rst) begin
         state  <= RUN;
         to_cnt <= '0;
         ld     <= '0;
         blink  <= 1'b0;
      end else begin
         state  <= state_nx;
         to_cnt <= to_cnt_nx;
         ld     <= ld_nx;
         blink  <= blink_nx;
      end
   end

endmodule
